// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, redirect/stall control and a registered IF/ID slot (1-cycle fetch latency, holds while out_ready=0).
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirects set a sticky trap and halt fetch instead of being aligned down.
module fetch_unit #(
   parameter int                ADDR_W      = 16,
   parameter int                INSTR_W     = 16,
   parameter int                INSTR_BYTES = 2,
   parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               pc_write,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_addr,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [ADDR_W-1:0]  out_pc,
   output logic [ADDR_W-1:0]  out_pc_next,
   output logic [INSTR_W-1:0] out_instr,
   output logic               misalign_trap
);

   localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(INSTR_BYTES);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INSTR_BYTES - 1);

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [ADDR_W-1:0]  pc_next;
      logic [INSTR_W-1:0] instr;
   } ifid_t;

   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] target;
   ifid_t             ifid;
   logic              valid;
   logic              trap;
   logic              flush;
   logic              load;
   logic              fire;

   assign pc_inc = pc + STEP;

`ifdef FETCH_MISALIGN_TRAP_EN
   logic misaligned;
   assign misaligned = |(redirect_addr & ALIGN_MASK);
   assign target     = redirect_addr;
   // Once trapped, redirects no longer flush or load anything.
   assign flush      = redirect_valid & ~trap;
   assign load       = flush & ~misaligned;

   always_ff @(posedge clk) begin
      if (reset) begin
         trap <= 1'b0;
      end else if (flush & misaligned) begin
         trap <= 1'b1;
      end
   end
`else
   assign target = redirect_addr & ~ALIGN_MASK;
   assign flush  = redirect_valid;
   assign load   = redirect_valid;
   assign trap   = 1'b0;
`endif

   assign fire = pc_write & (~valid | out_ready) & ~trap;

   always_ff @(posedge clk) begin
      if (reset) begin
         pc    <= RESET_ADDR;
         valid <= 1'b0;
         ifid  <= '0;
      end else if (flush) begin
         // Redirect discards the held instruction and this cycle's rdata.
         valid <= 1'b0;
         if (load) begin
            pc <= target;
         end
      end else if (fire) begin
         ifid.pc      <= pc;
         ifid.pc_next <= pc_inc;
         ifid.instr   <= imem_rdata;
         valid        <= 1'b1;
         pc           <= pc_inc;
      end else if (valid & out_ready) begin
         valid <= 1'b0;
      end
   end

   assign imem_addr     = pc;
   assign out_valid     = valid;
   assign out_pc        = ifid.pc;
   assign out_pc_next   = ifid.pc_next;
   assign out_instr     = ifid.instr;
   assign misalign_trap = trap;

endmodule
